// File: rtl/pc_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_ctrl_pkg
// Purpose : Shared types and constants for the branch-unit redirect interface.
//           The branch unit and pc_redirect_ctrl both import this package, so
//           redirect kinds, privilege levels and the privileged-routine
//           boundary have a single definition.
// Contents: redir_kind_t, cpl_t, fault_t, PRIV_ROUTINE_START
// Revision: 1.0 - initial release
// ============================================================================
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    KIND_BRANCH = 2'd0,
    KIND_JUMP   = 2'd1,
    KIND_ECALL  = 2'd2,
    KIND_ERET   = 2'd3
  } redir_kind_t;

  typedef enum logic {
    CPL_USER       = 1'b0,
    CPL_SUPERVISOR = 1'b1
  } cpl_t;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_PRIV_JUMP  = 2'd1,
    FAULT_MISALIGNED = 2'd2,
    FAULT_BAD_ERET   = 2'd3
  } fault_t;

  // First address of the privileged routine region. USER code may only enter
  // it through ECALL.
  localparam logic [63:0] PRIV_ROUTINE_START = 64'h0000_0000_0000_1000;

endpackage : pc_redirect_ctrl_pkg
`default_nettype wire

// File: rtl/pc_redirect_ctrl_legality_chk.sv
`default_nettype none
// ============================================================================
// Module  : redirect_legality_chk
// Purpose : Purely combinational legality check of a retired redirect against
//           the current privilege level. Rules are prioritised: bad ERET,
//           then privileged jump from USER, then misaligned target.
// Ports   : kind_i   - redirect kind
//           target_i - redirect target PC
//           cpl_i    - current privilege level
//           legal_o  - redirect may be taken
//           cause_o  - fault cause when illegal, FAULT_NONE otherwise
// Revision: 1.0 - initial release
// ============================================================================
module redirect_legality_chk
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  redir_kind_t           kind_i,
  input  logic [DATA_WIDTH-1:0] target_i,
  input  cpl_t                  cpl_i,
  output logic                  legal_o,
  output fault_t                cause_o
);

  // Compare in a width that holds both the target and the 64-bit boundary
  // constant, so narrow or wide PCs are compared without truncation.
  localparam int c_CMP_W = (DATA_WIDTH > 64) ? DATA_WIDTH : 64;

  logic [c_CMP_W-1:0] target_ext;
  logic [c_CMP_W-1:0] priv_ext;

  assign target_ext = c_CMP_W'(target_i);
  assign priv_ext   = c_CMP_W'(PRIV_ROUTINE_START);

  always_comb begin
    cause_o = FAULT_NONE;
    if (kind_i == KIND_ERET && cpl_i == CPL_USER) begin
      cause_o = FAULT_BAD_ERET;
    end else if (kind_i != KIND_ECALL && cpl_i == CPL_USER &&
                 target_ext >= priv_ext) begin
      cause_o = FAULT_PRIV_JUMP;
    end else if (target_i[1:0] != 2'b00) begin
      cause_o = FAULT_MISALIGNED;
    end
  end

  assign legal_o = (cause_o == FAULT_NONE);

endmodule : redirect_legality_chk
`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_ctrl
// Purpose : Owns the architectural fetch PC and privilege level. Accepts
//           retired redirects, flushes the pipeline for FLUSH_CYCLES cycles
//           and restarts fetch at the target; illegal redirects latch a
//           sticky fault that only reset clears.
// Ports   : clk, rst_n (async active-low)
//           redirect_valid_i/kind_i/pc_i - retired redirect from branch unit
//           fetch_pc_o/valid_o, fetch_ready_i - fetch handshake
//           flush_o          - kill younger in-flight work
//           cpl_o            - current privilege level
//           fault_o/cause_o  - sticky fault and its cause
//           redirect_count_o - legal redirect count (REDIRECT_COUNT_EN only)
// Options : define REDIRECT_COUNT_EN to add the saturating redirect counter.
// Revision: 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0,
  parameter int                    FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid_i,
  input  redir_kind_t           redirect_kind_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0] fetch_pc_o,
  output logic                  fetch_valid_o,
  input  logic                  fetch_ready_i,
  output logic                  flush_o,
  output cpl_t                  cpl_o,
  output logic                  fault_o,
`ifdef REDIRECT_COUNT_EN
  output logic [31:0]           redirect_count_o,
`endif
  output fault_t                fault_cause_o
);

  localparam logic [1:0] c_ST_RUN   = 2'd0;
  localparam logic [1:0] c_ST_FLUSH = 2'd1;
  localparam logic [1:0] c_ST_FAULT = 2'd2;

  localparam logic [3:0] c_FLUSH_INIT = 4'(FLUSH_CYCLES);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  cpl_t                  cpl_q, cpl_d;
  logic                  fault_q, fault_d;
  fault_t                cause_q, cause_d;
  // Holds fetch_valid_o low for the reset-release cycle.
  logic                  started_q;

  logic                  legal;
  fault_t                cause;
  logic                  accept;

  redirect_legality_chk #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_legality (
    .kind_i   (redirect_kind_i),
    .target_i (redirect_pc_i),
    .cpl_i    (cpl_q),
    .legal_o  (legal),
    .cause_o  (cause)
  );

  assign accept = (state_q == c_ST_RUN) && redirect_valid_i;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_RUN: begin
        if (redirect_valid_i) begin
          state_d = legal ? c_ST_FLUSH : c_ST_FAULT;
        end
      end
      c_ST_FLUSH: begin
        // Counter value 1 is the last flush cycle.
        if (cnt_q <= 4'd1) begin
          state_d = c_ST_RUN;
        end
      end
      c_ST_FAULT: state_d = c_ST_FAULT;
      default:    state_d = c_ST_RUN;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    fetch_valid_o = started_q && (state_q == c_ST_RUN);
    // In FAULT the counter is loaded with 1 on entry, giving a single-cycle
    // flush pulse.
    flush_o       = (state_q == c_ST_FLUSH) ||
                    ((state_q == c_ST_FAULT) && (cnt_q != 4'd0));
    fetch_pc_o    = pc_q;
    cpl_o         = cpl_q;
    fault_o       = fault_q;
    fault_cause_o = cause_q;
  end

  // ---------------------------------------------------------- datapath next
  always_comb begin
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    cpl_d   = cpl_q;
    fault_d = fault_q;
    cause_d = cause_q;
    case (state_q)
      c_ST_RUN: begin
        if (accept) begin
          if (legal) begin
            // Redirect wins over a simultaneous fetch handshake.
            cnt_d = c_FLUSH_INIT;
            pc_d  = redirect_pc_i;
            if (redirect_kind_i == KIND_ECALL) begin
              cpl_d = CPL_SUPERVISOR;
            end else if (redirect_kind_i == KIND_ERET) begin
              cpl_d = CPL_USER;
            end
          end else begin
            cnt_d   = 4'd1;
            fault_d = 1'b1;
            cause_d = cause;
          end
        end else if (fetch_valid_o && fetch_ready_i) begin
          pc_d = pc_q + DATA_WIDTH'(4);
        end
      end
      c_ST_FLUSH: begin
        cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
      end
      c_ST_FAULT: begin
        cnt_d = 4'd0;
      end
      default: begin
        cnt_d = 4'd0;
      end
    endcase
  end

  // ----------------------------------------------------------- datapath regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 4'd0;
      pc_q      <= RESET_PC;
      cpl_q     <= CPL_USER;
      fault_q   <= 1'b0;
      cause_q   <= FAULT_NONE;
      started_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      cpl_q     <= cpl_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
      started_q <= 1'b1;
    end
  end

`ifdef REDIRECT_COUNT_EN
  // Counts legal redirects accepted in RUN; saturates at all ones.
  logic [31:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else if (accept && legal && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign redirect_count_o = count_q;
`endif

endmodule : pc_redirect_ctrl
`default_nettype wire

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Consumer end of the branch-unit redirect interface. It takes retired control-flow redirects (branch, jump, ECALL, ERET), owns the architectural fetch PC and the current privilege level, and sequences the pipeline flush and fetch restart. It also sources the privilege level that the branch unit checks, and turns illegal privileged jumps into a sticky fault instead of a simulation abort.

Parameters:
DATA_WIDTH, 64, PC / address width
RESET_PC, 64'h0, fetch PC after reset
FLUSH_CYCLES, 2, cycles flush_o is held per accepted redirect (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
redirect_valid_i  in  1  retired redirect present this cycle
redirect_kind_i  in  redir_kind_t (2)  BRANCH, JUMP, ECALL, ERET
redirect_pc_i  in  DATA_WIDTH  target PC computed by branch unit
fetch_pc_o  out  DATA_WIDTH  PC offered to fetch
fetch_valid_o  out  1  fetch_pc_o valid
fetch_ready_i  in  1  fetch accepts fetch_pc_o
flush_o  out  1  kill all in-flight younger work
cpl_o  out  cpl_t (1)  current privilege, USER / SUPERVISOR
fault_o  out  1  sticky fault, cleared only by reset
fault_cause_o  out  fault_t (2)  NONE, PRIV_JUMP, MISALIGNED, BAD_ERET

Behaviour:
- Reset (async assert, sync-safe release): state RUN, fetch_pc_o=RESET_PC, fetch_valid_o=0, flush_o=0, cpl_o=USER, fault_o=0, fault_cause_o=NONE, flush counter 0. fetch_valid_o rises in the first cycle after deassertion.
- States: RUN, FLUSH, FAULT.
- RUN:
  - fetch_valid_o=1.
  - On fetch_valid_o & fetch_ready_i, fetch_pc_o += 4, wrapping modulo 2^DATA_WIDTH.
- Redirect accepted in RUN when redirect_valid_i=1. Legality is checked in priority order:
  1. kind==ERET and cpl_o==USER -> BAD_ERET.
  2. kind!=ECALL and cpl_o==USER and redirect_pc_i >= PRIV_ROUTINE_START -> PRIV_JUMP.
  3. redirect_pc_i[1:0]!=0 -> MISALIGNED.
- Legal redirect, at the accepting edge:
  - fetch_pc_o <= redirect_pc_i.
  - cpl_o <= SUPERVISOR on ECALL, USER on ERET, unchanged otherwise.
  - Go to FLUSH with counter=FLUSH_CYCLES.
- Redirect wins over a simultaneous fetch handshake; that handshake does not increment the PC.
- FLUSH:
  - flush_o=1, fetch_valid_o=0, counter decrements each cycle.
  - At counter==1, go to RUN next cycle.
  - Net latency: target appears with fetch_valid_o=1 exactly FLUSH_CYCLES+1 cycles after the redirect cycle.
  - redirect_valid_i during FLUSH is ignored; no state change.
- Illegal redirect:
  - Go to FAULT, fault_o<=1, fault_cause_o<=cause.
  - fetch_pc_o and cpl_o are not updated.
- FAULT:
  - flush_o=1 for the first cycle only, then 0; fetch_valid_o=0.
  - All inputs ignored until reset.
- Reset asserted mid-FLUSH or in FAULT returns immediately to reset values.

Optional Feature:
REDIRECT_COUNT_EN:
- Enabled: adds output redirect_count_o [31:0], reset 0.
  - Increments by 1 on every accepted legal redirect.
  - Saturates at 32'hFFFF_FFFF.
  - Illegal redirects and redirects ignored in FLUSH are not counted.
- Disabled: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared types package holds redir_kind_t, cpl_t (USER=0, SUPERVISOR=1), fault_t, and the existing PRIV_ROUTINE_START constant; the branch unit and this block use the same definitions.
- One sub-module: redirect_legality_chk, purely combinational. Inputs are kind, target and cpl; outputs are legal and cause.

Test Plan:
- Reset release with RESET_PC=0 and fetch_ready_i=1 for 3 cycles -> fetch_pc_o sequence 0x0, 0x4, 0x8; cpl_o=USER.
- JUMP to 0x100 in USER with FLUSH_CYCLES=2 -> flush_o high for 2 cycles, fetch_valid_o low; fetch_pc_o=0x100 with valid in cycle 3.
- ECALL to PRIV_ROUTINE_START from USER -> no fault, cpl_o=SUPERVISOR. Then ERET to 0x204 -> cpl_o=USER, fetch restarts at 0x204.
- USER JUMP to PRIV_ROUTINE_START+8 -> fault_o=1, cause PRIV_JUMP, flush_o pulse of 1 cycle, fetch_valid_o stays 0. Later redirects are ignored; rst_n low clears everything.
- BRANCH to 0x102 -> cause MISALIGNED. ERET in USER -> cause BAD_ERET. A second redirect arriving in the FLUSH cycle after a legal one -> ignored, first target used.
- REDIRECT_COUNT_EN defined: 5 legal redirects plus 1 ignored -> redirect_count_o=5.
